// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic-array feeder blocks.
package systolic_pkg;

    // Feeder sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feeder_state_e;

    // Number of STREAM cycles needed to push a DIM x DIM matrix through a
    // skewed edge: the last lane starts DIM-1 cycles late and runs DIM cycles,
    // and the trailing DIM-1 zero cycles flush the array.
    function automatic int stream_len(input int dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One skewed output lane: picks element (t - LANE) of its source vector,
// or zero when that index falls before the start or past the end of the
// vector. The subtraction is range-checked, so it never wraps.
module skew_lane #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    parameter int T_W     = 5,
    parameter int LANE    = 0
) (
    input  logic        [T_W-1:0]     t,
    input  logic signed [BITS_AB-1:0] vec [DIM],
    output logic signed [BITS_AB-1:0] elem
);

    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;

    logic [T_W-1:0] idx;

    // Select the delayed element, zero outside the valid window.
    always_comb begin
        idx  = t - T_W'(LANE);
        elem = '0;
        if ((t >= T_W'(LANE)) && (idx < T_W'(DIM))) begin
            elem = vec[idx[IW-1:0]];
        end
    end

endmodule

// File: rtl/skew_feeder.sv
// Skew feeder: stores a DIM x DIM operand matrix and streams it into a
// systolic array edge with lane i delayed by i cycles, followed by zero flush.
// Optional build macro FEEDER_TRANSPOSE_EN streams columns instead of rows
// (lane i carries column i), for feeding the B operand edge.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; matrix writes accepted
// STREAM | t runs 0..3*DIM-3, skewed lanes and en_out/busy driven
// DONE   | single-cycle completion pulse; matrix writes accepted
module skew_feeder
    import systolic_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      WrEn,
    input  logic [$clog2(DIM)-1:0]    wr_row,
    input  logic signed [BITS_AB-1:0] wr_data [DIM],
    input  logic                      start,
    output logic signed [BITS_AB-1:0] A_out [DIM],
    output logic                      en_out,
    output logic                      busy,
    output logic                      done
);

    localparam int             STREAM_LEN = stream_len(DIM);
    localparam int             T_W        = $clog2(STREAM_LEN + 1);
    localparam logic [T_W-1:0] T_LAST     = T_W'(STREAM_LEN - 1);

    feeder_state_e state_q, state_d;
    logic [T_W-1:0] t_q, t_d;

    logic signed [BITS_AB-1:0] m_q [DIM][DIM];
    logic signed [BITS_AB-1:0] m_d [DIM][DIM];

    logic signed [BITS_AB-1:0] a_q [DIM];
    logic signed [BITS_AB-1:0] a_d [DIM];
    logic signed [BITS_AB-1:0] lane_elem [DIM];

    logic en_q, en_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic wr_ok;

    // Writes are locked out while a stream is reading the matrix.
    assign wr_ok = WrEn && (state_q != STREAM);

    // Next-state and stream counter.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    t_d     = '0;
                end
            end
            STREAM: begin
                if (t_q == T_LAST) begin
                    state_d = DONE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Matrix write; the lanes read m_d so a write on the start edge is
    // already visible in the first streamed cycle.
    always_comb begin
        m_d = m_q;
        if (wr_ok) begin
            m_d[wr_row] = wr_data;
        end
    end

    // One lane selector per output; outputs are computed from the next
    // state so that the registered values line up with the current t.
    for (genvar g = 0; g < DIM; g++) begin : g_lane
        logic signed [BITS_AB-1:0] lane_vec [DIM];
        logic signed [BITS_AB-1:0] elem;

`ifdef FEEDER_TRANSPOSE_EN
        // Lane g carries column g.
        always_comb begin
            for (int j = 0; j < DIM; j++) begin
                lane_vec[j] = m_d[j][g];
            end
        end
`else
        // Lane g carries row g.
        always_comb begin
            lane_vec = m_d[g];
        end
`endif

        skew_lane #(
            .BITS_AB (BITS_AB),
            .DIM     (DIM),
            .T_W     (T_W),
            .LANE    (g)
        ) u_lane (
            .t    (t_d),
            .vec  (lane_vec),
            .elem (elem)
        );

        assign lane_elem[g] = elem;
    end

    // Registered output values for the coming cycle.
    always_comb begin
        en_d   = (state_d == STREAM);
        busy_d = (state_d == STREAM);
        done_d = (state_d == DONE);
        for (int i = 0; i < DIM; i++) begin
            a_d[i] = en_d ? lane_elem[i] : '0;
        end
    end

    // State, matrix and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                a_q[i] <= '0;
                for (int j = 0; j < DIM; j++) begin
                    m_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            m_q     <= m_d;
        end
    end

    assign A_out  = a_q;
    assign en_out = en_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_skew_feeder.sv
// Self-checking bench for skew_feeder (DIM=8, BITS_AB=8). Expected output
// frames come from a bench-side matrix model and are queued when a stream
// is launched, then popped one per cycle against the DUT outputs.
module tb_skew_feeder;

    localparam int DIM  = 8;
    localparam int BITS = 8;
    localparam int SLEN = 3 * DIM - 2;

    typedef struct packed {
        logic                     en;
        logic                     busy;
        logic                     done;
        logic [DIM-1:0][BITS-1:0] a;
    } frame_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   wr_en = 1'b0;
    logic [2:0]             wr_row = '0;
    logic signed [BITS-1:0] wdata [DIM];
    logic                   start = 1'b0;
    logic signed [BITS-1:0] a_out [DIM];
    logic                   en_out;
    logic                   busy;
    logic                   done;

    logic signed [BITS-1:0] mm [DIM][DIM];
    frame_t                 sb [$];
    int                     tests_run = 0;
    int                     tests_failed = 0;

    skew_feeder #(.BITS_AB(BITS), .DIM(DIM)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .WrEn    (wr_en),
        .wr_row  (wr_row),
        .wr_data (wdata),
        .start   (start),
        .A_out   (a_out),
        .en_out  (en_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    function automatic frame_t observe();
        frame_t f;
        f.en   = en_out;
        f.busy = busy;
        f.done = done;
        for (int i = 0; i < DIM; i++) f.a[i] = a_out[i];
        return f;
    endfunction

    function automatic frame_t exp_frame(input int t, input bit en, input bit dn);
        frame_t f;
        f      = '0;
        f.en   = en;
        f.busy = en;
        f.done = dn;
        if (en) begin
            for (int i = 0; i < DIM; i++) begin
                int j;
                j = t - i;
                if (j >= 0 && j < DIM) begin
`ifdef FEEDER_TRANSPOSE_EN
                    f.a[i] = mm[j][i];
`else
                    f.a[i] = mm[i][j];
`endif
                end
            end
        end
        return f;
    endfunction

    task automatic push_stream();
        for (int t = 0; t < SLEN; t++) sb.push_back(exp_frame(t, 1'b1, 1'b0));
        sb.push_back(exp_frame(0, 1'b0, 1'b1));
        sb.push_back(exp_frame(0, 1'b0, 1'b0));
    endtask

    // Stimulus only: write wdata into row r while idle, mirror into model.
    task automatic write_row(input int r);
        wr_en  = 1'b1;
        wr_row = 3'(r);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        for (int j = 0; j < DIM; j++) mm[r][j] = wdata[j];
    endtask

    task automatic test_reset();
        frame_t got;
        for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) mm[i][j] = '0;
        for (int j = 0; j < DIM; j++) wdata[j] = '0;
        repeat (2) @(negedge clk);
        got = observe();
        tests_run++;
        if (got !== frame_t'(0)) begin
            tests_failed++;
            $display("FAIL reset_outputs: got=%h required=0", got);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        frame_t got, exp;
        int en_cnt, done_at, n;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) wdata[j] = 8'(8 * i + j);
            write_row(i);
        end
        start = 1'b1;
        push_stream();
        n = sb.size();
        en_cnt = 0;
        done_at = -1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            got = observe();
            exp = sb.pop_front();
            if (got.en) en_cnt++;
            if (got.done && done_at < 0) done_at = c + 1;
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL stream_frame c=%0d: got=%h required=%h", c, got, exp);
            end
            if (c == 0) begin
                tests_run++;
                if (got.a !== '0) begin
                    tests_failed++;
                    $display("FAIL stream_t0: got=%h required=0", got.a);
                end
            end
            if (c == 7) begin
                tests_run++;
                if (a_out[0] !== 8'sd7 || a_out[7] !== 8'sd56) begin
                    tests_failed++;
                    $display("FAIL stream_t7: got lane0=%0d lane7=%0d required 7,56", a_out[0], a_out[7]);
                end
            end
            if (c == 14) begin
                tests_run++;
                if (got.a !== {8'd63, {7{8'd0}}}) begin
                    tests_failed++;
                    $display("FAIL stream_t14: got=%h required lane7=63 others 0", got.a);
                end
            end
        end
        tests_run++;
        if (en_cnt !== 22 || done_at !== 23) begin
            tests_failed++;
            $display("FAIL stream_len: got en=%0d done_cycle=%0d required 22,23", en_cnt, done_at);
        end
    endtask

    task automatic test_lane_select();
        int v1, v2;
        start = 1'b1;
        for (int c = 0; c < SLEN + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (c == 1) v1 = int'(a_out[1]);
            if (c == 2) v2 = int'(a_out[1]);
        end
        tests_run++;
`ifdef FEEDER_TRANSPOSE_EN
        if (v1 !== 1 || v2 !== 9) begin
            tests_failed++;
            $display("FAIL lane1_transpose: got %0d,%0d required 1,9", v1, v2);
        end
`else
        if (v1 !== 8 || v2 !== 9) begin
            tests_failed++;
            $display("FAIL lane1_row: got %0d,%0d required 8,9", v1, v2);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        frame_t got, exp;
        int n;
        start = 1'b1;
        push_stream();
        push_stream();
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 2 * SLEN + 2) start = 1'b0;
            got = observe();
            exp = sb.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL back_to_back c=%0d: got=%h required=%h", c, got, exp);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_write_during_stream();
        frame_t got, exp;
        int n, exp3a, exp3b;
`ifdef FEEDER_TRANSPOSE_EN
        exp3a = 3;
        exp3b = 59;
`else
        exp3a = 24;
        exp3b = 31;
`endif
        start = 1'b1;
        push_stream();
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (c == 5) begin
                for (int j = 0; j < DIM; j++) wdata[j] = -8'sd1;
                wr_row = 3'd3;
                wr_en  = 1'b1;
            end
            got = observe();
            exp = sb.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL wr_in_stream c=%0d: got=%h required=%h", c, got, exp);
            end
        end
        wr_en = 1'b0;
        start = 1'b1;
        push_stream();
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            got = observe();
            exp = sb.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL wr_after_stream c=%0d: got=%h required=%h", c, got, exp);
            end
            if (c == 3 || c == 10) begin
                tests_run++;
                if (int'(a_out[3]) !== ((c == 3) ? exp3a : exp3b)) begin
                    tests_failed++;
                    $display("FAIL row3_kept c=%0d: got %0d required %0d", c, a_out[3], (c == 3) ? exp3a : exp3b);
                end
            end
        end
    endtask

    task automatic test_write_and_start();
        frame_t got, exp;
        int n;
        for (int j = 0; j < DIM; j++) wdata[j] = 8'sd5;
        wr_row = 3'd0;
        wr_en  = 1'b1;
        start  = 1'b1;
        for (int j = 0; j < DIM; j++) mm[0][j] = 8'sd5;
        push_stream();
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            wr_en = 1'b0;
            start = 1'b0;
            got = observe();
            exp = sb.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL wr_start c=%0d: got=%h required=%h", c, got, exp);
            end
            if (c == 0) begin
                tests_run++;
                if (a_out[0] !== 8'sd5) begin
                    tests_failed++;
                    $display("FAIL wr_start_t0: got %0d required 5", a_out[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        frame_t got, exp;
        int n;
        start = 1'b1;
        push_stream();
        for (int c = 0; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            got = observe();
            exp = sb.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL pre_abort c=%0d: got=%h required=%h", c, got, exp);
            end
        end
        sb.delete();
        rst_n = 1'b0;
        #1;
        got = observe();
        tests_run++;
        if (got !== frame_t'(0)) begin
            tests_failed++;
            $display("FAIL abort_now: got=%h required=0", got);
        end
        for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) mm[i][j] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            got = observe();
            tests_run++;
            if (got !== frame_t'(0)) begin
                tests_failed++;
                $display("FAIL abort_quiet c=%0d: got=%h required=0", c, got);
            end
        end
        start = 1'b1;
        push_stream();
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            got = observe();
            exp = sb.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL post_reset c=%0d: got=%h required=%h", c, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_lane_select();
        test_back_to_back();
        test_write_during_stream();
        test_write_and_start();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/skew_feeder.md
SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 SHALL have parameter BITS_AB, default 8, meaning signed operand width.
REQ-002 SHALL have parameter DIM, default 8, meaning matrix dimension and lane count.
REQ-003 SHALL have port clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port WrEn  input  1  writes one stored row.
REQ-006 SHALL have port wr_row  input  $clog2(DIM)  index of the row to write.
REQ-007 SHALL have port wr_data  input  signed [BITS_AB-1:0] x DIM  row contents; element j is column j.
REQ-008 SHALL have port start  input  1  request to begin a stream.
REQ-009 SHALL have port A_out  output  signed [BITS_AB-1:0] x DIM  skewed lanes to the array operand inputs.
REQ-010 SHALL have port en_out  output  1  array enable, high for the whole stream.
REQ-011 SHALL have port busy  output  1  high while the block is in STREAM.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL hold a DIM x DIM register matrix M.
REQ-014 SHALL write M[wr_row][j] = wr_data[j] for every j on a clock edge where WrEn=1 and the state is IDLE or DONE.
REQ-015 SHALL ignore WrEn while in STREAM.
REQ-016 SHALL implement the FSM states IDLE, STREAM and DONE with these transitions: IDLE->STREAM on start=1; STREAM->DONE when t=3*DIM-3; DONE->IDLE unconditionally.
REQ-017 SHALL ignore start while in STREAM or DONE, with no queuing.
REQ-018 SHALL apply a WrEn and start arriving on the same IDLE edge so that the write lands first and the stream uses the updated M.
REQ-019 SHALL keep a stream counter t that is 0 in the first STREAM cycle (the cycle after start is sampled), increments by 1 each cycle and ends at 3*DIM-3, giving 3*DIM-2 STREAM cycles.
REQ-020 SHALL drive A_out[i] = M[i][t-i] when 0 <= t-i < DIM, and 0 otherwise, so that lane i is delayed by i cycles and the array flushes with zeros.
REQ-021 SHALL register A_out, en_out, busy and done, with no combinational path from any input to any output.
REQ-022 SHALL drive en_out=1 and busy=1 in every STREAM cycle and 0 in every other cycle.
REQ-023 SHALL drive done=1 for exactly the single DONE cycle.
REQ-024 SHALL drive A_out to all zeros outside STREAM.
REQ-025 SHALL compute the index t-i without wrap-around; negative values and values >= DIM both select zero.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force state=IDLE, t=0, M=all zeros, A_out=0, en_out=0, busy=0 and done=0.
REQ-027 SHALL, on reset asserted mid-stream, immediately abort the stream with no done pulse and leave all outputs at their reset values.
REQ-028 SHALL accept WrEn and start from the first clock edge after rst_n deasserts.

Configuration
REQ-029 SHALL, when macro FEEDER_TRANSPOSE_EN is defined, drive A_out[i] = M[t-i][i] instead, so that lane i streams column i and the block can feed the B operand edge.
REQ-030 SHALL, when FEEDER_TRANSPOSE_EN is undefined, stream rows per REQ-020 and contain no transpose multiplexing logic.

Structure
REQ-031 SHALL take the state enum type (IDLE, STREAM, DONE) from the shared package systolic_pkg.
REQ-032 SHALL take the stream-length constant, 3*DIM-2 expressed as a function of DIM, from systolic_pkg.
REQ-033 SHALL contain exactly one sub-module, skew_lane, with one instance per lane; each instance selects its lane element from t and the lane index.

Verification (DIM=8, BITS_AB=8)
REQ-034 SHALL cover: write M[i][j]=8*i+j for all rows, then start -> first STREAM cycle A_out={0,...,0,0} except A_out[0]=0; at t=7 A_out[0]=7 and A_out[7]=56; at t=14 A_out[7]=63 and all other lanes 0; en_out high for exactly 22 cycles; done high on cycle 23.
REQ-035 SHALL cover: start held high continuously -> streams run back-to-back with exactly one DONE cycle and one IDLE cycle between them; start during busy is never queued.
REQ-036 SHALL cover: WrEn to row 3 with all elements -1 mid-stream -> M unchanged; a following stream shows the original row 3 values on lane 3.
REQ-037 SHALL cover: WrEn and start on the same edge, row 0 all elements 5 -> A_out[0]=5 at t=0.
REQ-038 SHALL cover: rst_n=0 at t=10 -> en_out, busy and A_out are 0 immediately, no done pulse, and a later stream outputs all zeros.
REQ-039 SHALL cover: FEEDER_TRANSPOSE_EN defined with M[i][j]=8*i+j -> A_out[1]=1 at t=1 and A_out[1]=9 at t=2.
